// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch controller between program counter and decode
//
// Fetches the word at the current PC from instruction memory, latches it into the
// instruction register and offers it to decode with a valid/ack handshake. Drives the
// PC increment/load controls, including branch redirects, which take priority in every
// state.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a memory read that has not returned
// after TIMEOUT cycles in WAIT (sticky fetch_err, cleared by reset or br_req).
//
// Parameters:
//   AW       address width (PC width)
//   DW       instruction word width
//   TIMEOUT  WAIT cycles before abort (FETCH_TIMEOUT_EN only)
//
// Ports:
//   clk        in   clock, rising edge
//   re         in   asynchronous active-low reset
//   en         in   fetch enable
//   pc_addr    in   current PC value
//   pc_inc     out  one-cycle PC increment pulse
//   pc_l       out  one-cycle PC load pulse
//   pc_load    out  PC load value (branch target)
//   mem_addr   out  instruction memory address
//   mem_cs     out  memory chip select
//   mem_r      out  memory read strobe
//   mem_rdata  in   memory read data
//   mem_ready  in   read data valid this cycle
//   ir         out  instruction register
//   ir_valid   out  ir holds an unconsumed instruction
//   ir_ack     in   decode consumes ir
//   br_req     in   branch redirect request
//   br_target  in   branch target address
//   fetch_err  out  fetch timeout flag (constant 0 without FETCH_TIMEOUT_EN)

module instr_fetch #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          re,
   input  logic          en,
   input  logic [AW-1:0] pc_addr,
   output logic          pc_inc,
   output logic          pc_l,
   output logic [AW-1:0] pc_load,
   output logic [AW-1:0] mem_addr,
   output logic          mem_cs,
   output logic          mem_r,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   input  logic          ir_ack,
   input  logic          br_req,
   input  logic [AW-1:0] br_target,
   output logic          fetch_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] mem_addr_nxt;
   logic [AW-1:0] pc_load_nxt;
   logic [DW-1:0] ir_nxt;
   logic          mem_cs_nxt;
   logic          mem_r_nxt;
   logic          pc_inc_nxt;
   logic          pc_l_nxt;
   logic          ir_valid_nxt;
   logic          fetch_err_nxt;

`ifdef FETCH_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      mem_addr_nxt  = mem_addr;
      mem_cs_nxt    = mem_cs;
      mem_r_nxt     = mem_r;
      pc_inc_nxt    = 1'b0;
      pc_l_nxt      = 1'b0;
      pc_load_nxt   = pc_load;
      ir_nxt        = ir;
      ir_valid_nxt  = ir_valid;
      fetch_err_nxt = fetch_err;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_nxt  = wait_cnt;
`endif

      if (br_req) begin
         // Redirect drops whatever is in flight, including data returning this cycle.
         pc_l_nxt      = 1'b1;
         pc_load_nxt   = br_target;
         mem_cs_nxt    = 1'b0;
         mem_r_nxt     = 1'b0;
         ir_valid_nxt  = 1'b0;
         fetch_err_nxt = 1'b0;
         state_nxt     = en ? REQ : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en && !fetch_err) begin
                  state_nxt = REQ;
               end
            end
            REQ: begin
               // Straight after a redirect the PC loads on this same edge, so
               // pc_addr is still stale; take the target from our own pc_load.
               mem_addr_nxt = pc_l ? pc_load : pc_addr;
               mem_cs_nxt   = 1'b1;
               mem_r_nxt    = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt_nxt = '0;
`endif
               state_nxt    = WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  ir_nxt       = mem_rdata;
                  ir_valid_nxt = 1'b1;
                  mem_cs_nxt   = 1'b0;
                  mem_r_nxt    = 1'b0;
                  pc_inc_nxt   = 1'b1;
                  state_nxt    = HOLD;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  mem_cs_nxt    = 1'b0;
                  mem_r_nxt     = 1'b0;
                  fetch_err_nxt = 1'b1;
                  state_nxt     = IDLE;
               end else begin
                  wait_cnt_nxt = wait_cnt + CW'(1);
               end
`endif
            end
            HOLD: begin
               if (ir_ack) begin
                  ir_valid_nxt = 1'b0;
                  state_nxt    = en ? REQ : IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_cs    <= 1'b0;
         mem_r     <= 1'b0;
         pc_inc    <= 1'b0;
         pc_l      <= 1'b0;
         pc_load   <= '0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         fetch_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_cs    <= mem_cs_nxt;
         mem_r     <= mem_r_nxt;
         pc_inc    <= pc_inc_nxt;
         pc_l      <= pc_l_nxt;
         pc_load   <= pc_load_nxt;
         ir        <= ir_nxt;
         ir_valid  <= ir_valid_nxt;
         fetch_err <= fetch_err_nxt;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt  <= wait_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch

module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        re = 1'b1;
   logic        en = 1'b0;
   logic [15:0] pc_addr;
   logic        pc_inc;
   logic        pc_l;
   logic [15:0] pc_load;
   logic [15:0] mem_addr;
   logic        mem_cs;
   logic        mem_r;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ready = 1'b0;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ack = 1'b0;
   logic        br_req = 1'b0;
   logic [15:0] br_target = 16'h0000;
   logic        fetch_err;

   logic [15:0] pc = 16'h0000;
   logic        pc_set = 1'b0;
   logic [15:0] pc_set_val = 16'h0000;
   int          inc_cnt = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   instr_fetch #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
      .clk(clk), .re(re), .en(en), .pc_addr(pc_addr),
      .pc_inc(pc_inc), .pc_l(pc_l), .pc_load(pc_load),
      .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_r(mem_r),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack),
      .br_req(br_req), .br_target(br_target), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // Program counter model driven by the DUT's pc_inc / pc_l pulses.
   always @(posedge clk or negedge re) begin
      if (!re)         pc <= 16'h0000;
      else if (pc_set) pc <= pc_set_val;
      else if (pc_l)   pc <= pc_load;
      else if (pc_inc) pc <= pc + 16'h0001;
   end
   assign pc_addr = pc;

   always @(posedge clk) begin
      if (pc_inc) inc_cnt <= inc_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 re = 1'b0;
      #1;
      tick();
      n_cmp++; if ({mem_cs, mem_r, pc_inc, pc_l, ir_valid, fetch_err} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags: got %b expected 000000", {mem_cs, mem_r, pc_inc, pc_l, ir_valid, fetch_err}); end
      n_cmp++; if ({mem_addr, pc_load, ir} !== 48'h0) begin
         n_err++; $display("FAIL reset_words: got %h expected 0", {mem_addr, pc_load, ir}); end
      re = 1'b1;
      tick();
      tick();
      n_cmp++; if (mem_cs !== 1'b0) begin
         n_err++; $display("FAIL reset_idle_en0: mem_cs got %b expected 0", mem_cs); end
   endtask

   task automatic test_fetch_hold();
      int inc_before;
      inc_before = inc_cnt;
      en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1234;
      tick();
      n_cmp++; if (mem_cs !== 1'b0) begin
         n_err++; $display("FAIL t1_req_cs: got %b expected 0", mem_cs); end
      tick();
      n_cmp++; if ({mem_cs, mem_r} !== 2'b11) begin
         n_err++; $display("FAIL t1_cs_r: got %b expected 11", {mem_cs, mem_r}); end
      n_cmp++; if (mem_addr !== 16'h0000) begin
         n_err++; $display("FAIL t1_mem_addr: got %h expected 0000", mem_addr); end
      tick();
      n_cmp++; if ({ir_valid, pc_inc, mem_cs} !== 3'b110) begin
         n_err++; $display("FAIL t1_capture: {ir_valid,pc_inc,mem_cs} got %b expected 110", {ir_valid, pc_inc, mem_cs}); end
      n_cmp++; if (ir !== 16'h1234) begin
         n_err++; $display("FAIL t1_ir: got %h expected 1234", ir); end
      tick();
      n_cmp++; if (pc_inc !== 1'b0) begin
         n_err++; $display("FAIL t1_inc_pulse: got %b expected 0", pc_inc); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         n_cmp++; if ({ir_valid, mem_cs} !== 2'b10) begin
            n_err++; $display("FAIL t2_hold_%0d: {ir_valid,mem_cs} got %b expected 10", i, {ir_valid, mem_cs}); end
      end
      n_cmp++; if (inc_cnt - inc_before !== 1) begin
         n_err++; $display("FAIL t2_inc_count: got %0d expected 1", inc_cnt - inc_before); end
      ir_ack = 1'b1; en = 1'b0;
      tick();
      ir_ack = 1'b0;
      n_cmp++; if (ir_valid !== 1'b0) begin
         n_err++; $display("FAIL t2_ack: ir_valid got %b expected 0", ir_valid); end
      n_cmp++; if (ir !== 16'h1234) begin
         n_err++; $display("FAIL t2_ir_retain: got %h expected 1234", ir); end
      tick();
      n_cmp++; if (mem_cs !== 1'b0) begin
         n_err++; $display("FAIL t2_idle: mem_cs got %b expected 0", mem_cs); end
   endtask

   task automatic test_branch();
      en = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      n_cmp++; if ({mem_cs, mem_addr} !== {1'b1, 16'h0001}) begin
         n_err++; $display("FAIL t3_wait: {cs,addr} got %h expected 10001", {mem_cs, mem_addr}); end
      br_req = 1'b1; br_target = 16'h03E8; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      br_req = 1'b0; mem_rdata = 16'h5555;
      n_cmp++; if ({pc_l, pc_inc, ir_valid, mem_cs} !== 4'b1000) begin
         n_err++; $display("FAIL t3_branch_flags: {pc_l,pc_inc,ir_valid,mem_cs} got %b expected 1000", {pc_l, pc_inc, ir_valid, mem_cs}); end
      n_cmp++; if (pc_load !== 16'h03E8) begin
         n_err++; $display("FAIL t3_pc_load: got %h expected 03e8", pc_load); end
      n_cmp++; if (ir !== 16'h1234) begin
         n_err++; $display("FAIL t3_discard: ir got %h expected 1234", ir); end
      tick();
      n_cmp++; if ({mem_cs, mem_addr} !== {1'b1, 16'h03E8}) begin
         n_err++; $display("FAIL t3_redirect_addr: {cs,addr} got %h expected 103e8", {mem_cs, mem_addr}); end
      tick();
      n_cmp++; if ({ir_valid, ir} !== {1'b1, 16'h5555}) begin
         n_err++; $display("FAIL t3_refetch: {valid,ir} got %h expected 15555", {ir_valid, ir}); end
      en = 1'b0; ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      en = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      n_cmp++; if (mem_cs !== 1'b1) begin
         n_err++; $display("FAIL t4_pre_cs: got %b expected 1", mem_cs); end
      #3 re = 1'b0; en = 1'b0;
      #1;
      n_cmp++; if ({mem_cs, mem_r, ir_valid} !== 3'b000) begin
         n_err++; $display("FAIL t4_async_flags: got %b expected 000", {mem_cs, mem_r, ir_valid}); end
      n_cmp++; if (ir !== 16'h0000) begin
         n_err++; $display("FAIL t4_async_ir: got %h expected 0000", ir); end
      tick();
      re = 1'b1;
      tick(); tick(); tick();
      n_cmp++; if ({mem_cs, ir_valid} !== 2'b00) begin
         n_err++; $display("FAIL t4_stay_idle: {cs,valid} got %b expected 00", {mem_cs, ir_valid}); end
   endtask

   task automatic test_wrap_back_to_back();
      pc_set = 1'b1; pc_set_val = 16'hFFFF;
      tick();
      pc_set = 1'b0;
      en = 1'b1; mem_ready = 1'b1; ir_ack = 1'b1; mem_rdata = 16'hA5A5;
      tick();
      tick();
      n_cmp++; if ({mem_cs, mem_addr} !== {1'b1, 16'hFFFF}) begin
         n_err++; $display("FAIL t5_addr_ffff: {cs,addr} got %h expected 1ffff", {mem_cs, mem_addr}); end
      tick();
      n_cmp++; if (ir_valid !== 1'b1) begin
         n_err++; $display("FAIL t5_first_valid: got %b expected 1", ir_valid); end
      tick();
      n_cmp++; if (ir_valid !== 1'b0) begin
         n_err++; $display("FAIL t5_gap1: got %b expected 0", ir_valid); end
      tick();
      n_cmp++; if ({ir_valid, mem_cs, mem_addr} !== {2'b01, 16'h0000}) begin
         n_err++; $display("FAIL t5_addr_wrap: {valid,cs,addr} got %h expected 10000", {ir_valid, mem_cs, mem_addr}); end
      tick();
      n_cmp++; if (ir_valid !== 1'b1) begin
         n_err++; $display("FAIL t5_spacing: second ir_valid got %b expected 1", ir_valid); end
      en = 1'b0;
      tick();
      ir_ack = 1'b0;
      tick();
      n_cmp++; if ({ir_valid, mem_cs} !== 2'b00) begin
         n_err++; $display("FAIL t5_end_idle: {valid,cs} got %b expected 00", {ir_valid, mem_cs}); end
   endtask

   task automatic test_timeout();
      en = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
`ifdef FETCH_TIMEOUT_EN
      for (int i = 1; i < 15; i++) tick();
      n_cmp++; if ({mem_cs, fetch_err} !== 2'b10) begin
         n_err++; $display("FAIL t6_before_abort: {cs,err} got %b expected 10", {mem_cs, fetch_err}); end
      tick();
      n_cmp++; if ({mem_cs, fetch_err, pc_inc} !== 3'b010) begin
         n_err++; $display("FAIL t6_abort: {cs,err,inc} got %b expected 010", {mem_cs, fetch_err, pc_inc}); end
      tick(); tick(); tick();
      n_cmp++; if ({mem_cs, fetch_err} !== 2'b01) begin
         n_err++; $display("FAIL t6_sticky: {cs,err} got %b expected 01", {mem_cs, fetch_err}); end
      br_req = 1'b1; br_target = 16'h0010; en = 1'b0;
      tick();
      br_req = 1'b0;
      n_cmp++; if ({fetch_err, pc_l} !== 2'b01) begin
         n_err++; $display("FAIL t6_clear: {err,pc_l} got %b expected 01", {fetch_err, pc_l}); end
`else
      for (int i = 0; i < 20; i++) tick();
      n_cmp++; if ({mem_cs, fetch_err} !== 2'b10) begin
         n_err++; $display("FAIL t6_wait_forever: {cs,err} got %b expected 10", {mem_cs, fetch_err}); end
      br_req = 1'b1; br_target = 16'h0010; en = 1'b0;
      tick();
      br_req = 1'b0;
      n_cmp++; if ({mem_cs, pc_l, pc_load} !== {2'b01, 16'h0010}) begin
         n_err++; $display("FAIL t6_branch_out: {cs,pc_l,load} got %h expected 10010", {mem_cs, pc_l, pc_load}); end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch_hold();
      test_branch();
      test_reset_mid_wait();
      test_wrap_back_to_back();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
